// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Purpose : core-wide scalar types shared by the pipeline stage wrappers.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/pipereg_pkg.sv
// ---------------------------------------------------------------------------
// pipereg_pkg
// Purpose : shared types and constants for the elastic pipeline register.
// Ports   : none (package).
// Contents: pstate_t occupancy/state encoding (value equals entries held),
//           STATS_W width of the optional statistics counters, and WORD_W,
//           the machine-word width that stage wrappers size payloads from.
// ---------------------------------------------------------------------------
package pipereg_pkg;

    import cpu_types_pkg::*;

    // Encoding doubles as the occupancy count, so it must stay 0/1/2.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pstate_t;

    localparam int unsigned STATS_W = 32;
    localparam int unsigned WORD_W  = $bits(word_t);

endpackage

// File: rtl/pipereg_sat_ctr.sv
// ---------------------------------------------------------------------------
// pipereg_sat_ctr
// Purpose : up-counter that sticks at all-ones instead of wrapping.
// Ports   : CLK        in   clock, rising edge
//           nRST       in   asynchronous active-low reset, clears to 0
//           i_inc      in   count this cycle
//           i_load     in   load i_load_val (wins over i_inc)
//           i_load_val in   WIDTH value to load
//           o_count    out  WIDTH current count
// ---------------------------------------------------------------------------
module pipereg_sat_ctr
    import pipereg_pkg::*;
#(
    parameter int unsigned WIDTH = STATS_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             i_inc,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipereg_elastic.sv
// ---------------------------------------------------------------------------
// pipereg_elastic
// Purpose : generic pipeline stage register with valid/ready handshake and a
//           2-entry skid buffer; keeps the legacy WEN stall and flush (NOP
//           insertion) controls. in_ready depends only on registered state
//           and WEN, never on out_ready.
// Config  : define PIPEREG_STATS_EN to add the stall_cnt / bubble_cnt
//           saturating statistics counters.
// Ports   : CLK        in   clock, rising edge
//           nRST       in   asynchronous active-low reset
//           WEN        in   stage enable; 0 freezes state, blocks handshakes
//           flush      in   empty both entries at next edge (beats WEN)
//           in_valid   in   upstream payload valid
//           in_ready   out  stage can accept a payload
//           in_data    in   DATA_W upstream payload
//           out_valid  out  main entry valid and WEN
//           out_ready  in   downstream accepts
//           out_data   out  DATA_W main payload, BUBBLE_VAL when empty
//           occupancy  out  2-bit entries held (0..2)
//           stall_cnt  out  32 cycles out_valid & ~out_ready (stats only)
//           bubble_cnt out  32 cycles ~out_valid & out_ready & WEN (stats only)
// ---------------------------------------------------------------------------
module pipereg_elastic
    import pipereg_pkg::*;
#(
    parameter int unsigned         DATA_W     = 32,
    parameter logic [DATA_W-1:0]   BUBBLE_VAL = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              WEN,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPEREG_STATS_EN
    ,
    output logic [STATS_W-1:0] stall_cnt,
    output logic [STATS_W-1:0] bubble_cnt
`endif
);

    pstate_t           r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;

    logic w_main_vld;
    logic w_in_xfer;
    logic w_out_xfer;

    assign w_main_vld = (r_state != EMPTY);
    assign in_ready   = (r_state != FULL) && WEN;
    assign out_valid  = w_main_vld && WEN;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // Main is reloaded with BUBBLE_VAL whenever it empties, but gate anyway so
    // out_data is strictly a function of the main entry and its valid bit.
    assign out_data  = w_main_vld ? r_main : BUBBLE_VAL;
    assign occupancy = r_state;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= EMPTY;
            r_main  <= BUBBLE_VAL;
            r_skid  <= BUBBLE_VAL;
        end else if (flush) begin
            r_state <= EMPTY;
            r_main  <= BUBBLE_VAL;
            r_skid  <= BUBBLE_VAL;
        end else if (WEN) begin
            case (r_state)
                EMPTY: begin
                    if (w_in_xfer) begin
                        r_state <= ONE;
                        r_main  <= in_data;
                    end
                end
                ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_main <= in_data;
                    end else if (w_in_xfer) begin
                        r_state <= FULL;
                        r_skid  <= in_data;
                    end else if (w_out_xfer) begin
                        r_state <= EMPTY;
                        r_main  <= BUBBLE_VAL;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (w_out_xfer) begin
                        r_state <= ONE;
                        r_main  <= r_skid;
                        r_skid  <= BUBBLE_VAL;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_main  <= BUBBLE_VAL;
                    r_skid  <= BUBBLE_VAL;
                end
            endcase
        end
    end

`ifdef PIPEREG_STATS_EN
    logic w_stall_inc;
    logic w_bubble_inc;

    assign w_stall_inc  = out_valid && !out_ready;
    assign w_bubble_inc = !out_valid && out_ready && WEN;

    // Counters see only nRST; flush deliberately leaves them untouched.
    pipereg_sat_ctr #(
        .WIDTH (STATS_W)
    ) u_stall_ctr (
        .CLK        (CLK),
        .nRST       (nRST),
        .i_inc      (w_stall_inc),
        .i_load     (1'b0),
        .i_load_val ({STATS_W{1'b0}}),
        .o_count    (stall_cnt)
    );

    pipereg_sat_ctr #(
        .WIDTH (STATS_W)
    ) u_bubble_ctr (
        .CLK        (CLK),
        .nRST       (nRST),
        .i_inc      (w_bubble_inc),
        .i_load     (1'b0),
        .i_load_val ({STATS_W{1'b0}}),
        .o_count    (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipereg_elastic.sv
// ---------------------------------------------------------------------------
// tb_pipereg_elastic
// Purpose : self-checking bench for pipereg_elastic. A queue of accepted
//           payloads (capacity 2) serves as the reference model; directed
//           scenarios plus a randomized run are compared against it.
// ---------------------------------------------------------------------------
module tb_pipereg_elastic;

    localparam int unsigned DW  = 32;
    localparam logic [DW-1:0] BUB = 32'h0000_0013;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          WEN;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPEREG_STATS_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   bubble_cnt;
    logic          s_inc;
    logic          s_load;
    logic [31:0]   s_load_val;
    logic [31:0]   s_count;
`endif

    always #5 CLK = ~CLK;

    pipereg_elastic #(
        .DATA_W     (DW),
        .BUBBLE_VAL (BUB)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .WEN        (WEN),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy)
`ifdef PIPEREG_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

`ifdef PIPEREG_STATS_EN
    pipereg_sat_ctr #(
        .WIDTH (32)
    ) u_sat (
        .CLK        (CLK),
        .nRST       (nRST),
        .i_inc      (s_inc),
        .i_load     (s_load),
        .i_load_val (s_load_val),
        .o_count    (s_count)
    );
`endif

    // Reference model: payloads accepted and not yet delivered, oldest first.
    logic [DW-1:0] mq[$];
    int n_err = 0;
    int n_chk = 0;

    function automatic logic m_in_ready();
        return (mq.size() < 2) && WEN;
    endfunction

    function automatic logic m_out_valid();
        return (mq.size() > 0) && WEN;
    endfunction

    function automatic logic [DW-1:0] m_out_data();
        return (mq.size() > 0) ? mq[0] : BUB;
    endfunction

    // Advance one clock, applying the handshake rules to the model.
    task automatic tick();
        logic ix;
        logic ox;
        ix = in_valid && m_in_ready();
        ox = m_out_valid() && out_ready;
        @(posedge CLK);
        if (!nRST || flush) begin
            mq.delete();
        end else if (WEN) begin
            if (ox) void'(mq.pop_front());
            if (ix) mq.push_back(in_data);
        end
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; WEN = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        mq.delete();
        @(posedge CLK); #1;
        nRST = 1'b1;
        #1;
        n_chk++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== BUB
            || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_init occ=%0d ov=%b od=%h ir=%b exp 0 0 %h 1",
                     occupancy, out_valid, out_data, in_ready, BUB);
        end
        // Fill to occupancy 2, then drop nRST between edges.
        in_valid = 1'b1; in_data = 32'hAAAA_0001; #1; tick();
        in_data = 32'hAAAA_0002; #1; tick();
        in_valid = 1'b0;
        #1;
        n_chk++;
        if (occupancy !== 2'd2) begin
            n_err++;
            $display("FAIL reset_prefill occ got=%0d exp=2", occupancy);
        end
        nRST = 1'b0; flush = 1'b1;
        mq.delete();
        #1;
        n_chk++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== BUB
            || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_async occ=%0d ov=%b od=%h ir=%b exp 0 0 %h 1",
                     occupancy, out_valid, out_data, in_ready, BUB);
        end
        tick();
        n_chk++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold occ=%0d ov=%b exp 0 0", occupancy, out_valid);
        end
        flush = 1'b0;
        #2;
        nRST = 1'b1;
        #1;
    endtask

    task automatic test_streaming();
        WEN = 1'b1; out_ready = 1'b1; flush = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            #1;
            n_chk++;
            if (in_ready !== 1'b1 || occupancy !== ((i == 1) ? 2'd0 : 2'd1)) begin
                n_err++;
                $display("FAIL stream_ready i=%0d ir=%b occ=%0d", i, in_ready, occupancy);
            end
            if (i > 1) begin
                n_chk++;
                if (out_valid !== 1'b1 || out_data !== DW'(i - 1)) begin
                    n_err++;
                    $display("FAIL stream_data i=%0d ov=%b got=%h exp=%h",
                             i, out_valid, out_data, DW'(i - 1));
                end
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 32'h8 || occupancy !== 2'd1) begin
            n_err++;
            $display("FAIL stream_last ov=%b got=%h occ=%0d exp 1 8 1",
                     out_valid, out_data, occupancy);
        end
        tick();
        n_chk++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== BUB) begin
            n_err++;
            $display("FAIL stream_drain ov=%b occ=%0d od=%h", out_valid, occupancy, out_data);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp_seq [3];
        exp_seq[0] = 32'hA; exp_seq[1] = 32'hB; exp_seq[2] = 32'hC;
        WEN = 1'b1; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; #1; tick();
        in_data = 32'hB; #1;
        n_chk++;
        if (in_ready !== 1'b1 || out_data !== 32'hA) begin
            n_err++;
            $display("FAIL bp_second ir=%b od=%h exp 1 a", in_ready, out_data);
        end
        tick();
        in_data = 32'hC; #1;
        n_chk++;
        if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_data !== 32'hA) begin
            n_err++;
            $display("FAIL bp_full ir=%b occ=%0d od=%h exp 0 2 a",
                     in_ready, occupancy, out_data);
        end
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== exp_seq[k] || out_data !== m_out_data())
            begin
                n_err++;
                $display("FAIL bp_order k=%0d ov=%b got=%h exp=%h",
                         k, out_valid, out_data, exp_seq[k]);
            end
            tick();
            if (k == 1) in_valid = 1'b0;
        end
        #1;
        n_chk++;
        if (occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL bp_empty occ got=%0d exp=0", occupancy);
        end
    endtask

    task automatic test_stall();
        WEN = 1'b1; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h55; #1; tick();
        in_data = 32'h66; WEN = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_chk++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || occupancy !== 2'd1) begin
                n_err++;
                $display("FAIL stall_freeze c=%0d ov=%b ir=%b occ=%0d exp 0 0 1",
                         c, out_valid, in_ready, occupancy);
            end
            tick();
        end
        WEN = 1'b1; #1;
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 32'h55 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_resume ov=%b od=%h ir=%b exp 1 55 1",
                     out_valid, out_data, in_ready);
        end
        tick();
        in_valid = 1'b0; #1;
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 32'h66) begin
            n_err++;
            $display("FAIL stall_next ov=%b od=%h exp 1 66", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_flush();
        WEN = 1'b1; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11; #1; tick();
        in_data = 32'h22; #1; tick();
        in_data = 32'h33; WEN = 1'b0; flush = 1'b1; #1;
        tick();
        flush = 1'b0; WEN = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_chk++;
        if (occupancy !== 2'd0 || out_data !== BUB || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_empty occ=%0d od=%h ov=%b exp 0 %h 0",
                     occupancy, out_data, out_valid, BUB);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_chk++;
            if (out_valid !== 1'b0 || out_data === 32'h33) begin
                n_err++;
                $display("FAIL flush_dropped c=%0d ov=%b od=%h", c, out_valid, out_data);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            WEN       = ($urandom_range(7) != 0);
            flush     = ($urandom_range(15) == 0);
            in_valid  = $urandom_range(1);
            out_ready = ($urandom_range(3) != 0) ? $urandom_range(1) : 1'b1;
            in_data   = $urandom;
            #1;
            n_chk++;
            if (in_ready !== m_in_ready() || out_valid !== m_out_valid()
                || out_data !== m_out_data() || occupancy !== 2'(mq.size())) begin
                n_err++;
                $display("FAIL rand c=%0d ir=%b/%b ov=%b/%b od=%h/%h occ=%0d/%0d",
                         c, in_ready, m_in_ready(), out_valid, m_out_valid(),
                         out_data, m_out_data(), occupancy, mq.size());
            end
            tick();
        end
        flush = 1'b0;
        WEN   = 1'b1;
    endtask

`ifdef PIPEREG_STATS_EN
    task automatic test_stats();
        WEN = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        s_inc = 1'b0; s_load = 1'b0; s_load_val = '0;
        nRST = 1'b0; mq.delete(); #1; nRST = 1'b1; #1;
        in_valid = 1'b1; in_data = 32'h77; #1; tick();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        out_ready = 1'b1; tick();
        for (int c = 0; c < 3; c++) tick();
        out_ready = 1'b0; #1;
        n_chk++;
        if (stall_cnt !== 32'd5 || bubble_cnt !== 32'd3) begin
            n_err++;
            $display("FAIL stats_counts stall=%0d bubble=%0d exp 5 3", stall_cnt, bubble_cnt);
        end
        flush = 1'b1; tick(); flush = 1'b0; #1;
        n_chk++;
        if (stall_cnt !== 32'd5 || bubble_cnt !== 32'd3) begin
            n_err++;
            $display("FAIL stats_flush stall=%0d bubble=%0d exp 5 3", stall_cnt, bubble_cnt);
        end
        s_load = 1'b1; s_load_val = 32'hFFFF_FFFE; tick();
        s_load = 1'b0; s_inc = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        s_inc = 1'b0; #1;
        n_chk++;
        if (s_count !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL stats_saturate got=%h exp=ffffffff", s_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_stall();
        test_flush();
        test_random();
`ifdef PIPEREG_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipereg_elastic.md
Name: pipereg_elastic

Overview:
Generic, parametrised pipeline stage register that replaces the fixed per-stage latch interfaces (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Payload is an opaque DATA_W-bit vector; each stage packs its own fields into it.
- Adds a valid/ready handshake and a 2-entry skid buffer, so in_ready does not depend combinationally on out_ready.
- Keeps the legacy WEN (stall) and flush (NOP insertion) controls.

Parameters:
DATA_W, 32, payload width in bits; legal range 1..1024.
BUBBLE_VAL, 0, DATA_W-bit value driven on out_data while out_valid=0 and loaded into both entries on reset/flush (NOP encoding).

Ports:
CLK  in  1  clock; rising edge.
nRST  in  1  asynchronous, active-low reset.
WEN  in  1  stage enable; 0 freezes all state and blocks both handshakes.
flush  in  1  discard all contents at the next edge; takes priority over WEN and handshakes.
in_valid  in  1  upstream payload valid.
in_ready  out  1  stage can accept a payload: (state!=FULL) & WEN.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  main entry valid & WEN.
out_ready  in  1  downstream accepts.
out_data  out  DATA_W  main entry payload, or BUBBLE_VAL when the main entry is invalid.
occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Transfers:
  - in_xfer = in_valid & in_ready.
  - out_xfer = out_valid & out_ready.
  - Both require WEN=1.
- States: EMPTY (occ 0), ONE (main entry held), FULL (main + skid held).
- Reset (nRST=0, async):
  - state=EMPTY; main and skid = BUBBLE_VAL.
  - out_valid=0, occupancy=0, out_data=BUBBLE_VAL.
  - in_ready=WEN.
- flush=1 at an edge: next state=EMPTY and both entries = BUBBLE_VAL, regardless of WEN, in_xfer or out_xfer. An in_xfer in that same cycle is dropped.
- WEN=0, flush=0: every register holds its value.
- WEN=1, flush=0 transitions:
  - EMPTY: in_xfer -> ONE, main<=in_data; otherwise stay.
  - ONE: in_xfer & out_xfer -> ONE, main<=in_data.
  - ONE: in_xfer only -> FULL, skid<=in_data.
  - ONE: out_xfer only -> EMPTY, main<=BUBBLE_VAL.
  - ONE: neither -> hold.
  - FULL: in_ready=0; out_xfer -> ONE, main<=skid, skid<=BUBBLE_VAL; otherwise hold.
- Ordering: payloads leave in the order accepted; no loss or duplication except on flush.
- Latency: 1 cycle from in_xfer into EMPTY to out_valid=1.
- Throughput: 1 transfer/cycle sustained when out_ready=1.
- out_data is purely a function of the main entry and its valid bit; skid contents are never visible on out_data.
- A flush asserted while nRST=0 has no effect; reset dominates.
- occupancy is registered and equals the state encoding.

Optional Feature:
PIPEREG_STATS_EN
- Defined: adds two outputs.
  - stall_cnt, 32 bits: counts cycles with out_valid & ~out_ready.
  - bubble_cnt, 32 bits: counts cycles with ~out_valid & out_ready & WEN.
  - Both saturate at 32'hFFFFFFFF, reset to 0 on nRST only, and are unaffected by flush.
- Not defined: both ports and all counter logic are absent; all other behaviour is identical.

Decomposition:
- Package pipereg_pkg:
  - typedef enum logic [1:0] pstate_t {EMPTY=2'd0, ONE=2'd1, FULL=2'd2}.
  - localparam STATS_W=32.
  - Imports cpu_types_pkg for word_t, used by stage wrappers.
- Sub-module pipereg_sat_ctr (STATS_W-bit saturating counter with inc input), instantiated twice under PIPEREG_STATS_EN.

Test Plan:
- Reset: nRST=0 mid-stream with occ=2 -> out_valid=0 and occupancy=0 immediately (async); out_data=BUBBLE_VAL; in_ready=1 with WEN=1.
- Streaming: WEN=1, out_ready=1, send 0x1..0x8 back-to-back -> out_data 0x1..0x8 on consecutive cycles, first one cycle after its in_xfer; occupancy stays 1.
- Backpressure: out_ready=0, send 0xA, 0xB, 0xC -> 0xA, 0xB accepted, in_ready=0 and occupancy=2 with 0xC held off; then out_ready=1 -> 0xA, 0xB, 0xC delivered in order.
- Stall: WEN=0 for 3 cycles with occ=1 holding 0x55 and in_valid=1 -> out_valid=0, in_ready=0, no state change; WEN=1 -> 0x55 presented and transfer resumes.
- Flush: occ=2 (0x11, 0x22), flush=1 with in_valid=1 (0x33) and WEN=0 -> next cycle occupancy=0, out_data=BUBBLE_VAL, 0x33 never emerges.
- Stats (PIPEREG_STATS_EN): 5 cycles valid & ~out_ready, then 3 cycles empty & out_ready -> stall_cnt=5, bubble_cnt=3; a preloaded counter at 32'hFFFFFFFF stays saturated.
